usr_serial_sequencer: RTL and testbench

Controller that sequences one universal shift register instance. That register uses the mode encoding 00=hold, 01=shift left, 10=shift right, 11=parallel load. The block turns word-level commands into load/shift sequences:
- TX: serialise a word onto a 1-bit link.
- RX: deserialise 1..WIDTH link bits into a word.
It sits between a word-side command/response interface and the shift register plus serial link, and owns the register's mode, serial_in and data_in pins.

---
 rtl/usr_serial_sequencer.sv | 176 +++++++++++++++++
 tb/tb_usr_serial_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usr_serial_sequencer.sv
// usr_serial_sequencer
// Drives one universal shift register (00=hold, 01=shift left, 10=shift right,
// 11=parallel load) so that word-level commands become load/shift sequences:
//   TX: serialise a word onto a 1-bit link, LSB-first (op 00) or MSB-first (op 01).
//   RX: deserialise 1..WIDTH link bits into a right-aligned word, MSB-first
//       (op 10) or LSB-first (op 11).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/ready/op/len/data   word-side command channel
//   sr_mode/serial_in/data_in     control pins of the shift register
//   sr_data_out                   shift register contents
//   ser_out/ser_out_valid/ready   TX link (valid/ready)
//   ser_in/ser_in_valid           RX link (strobe, no backpressure)
//   rsp_valid/ready/data          RX word response
//   done                          registered one-cycle completion pulse
module usr_serial_sequencer #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_len,
   input  logic [WIDTH-1:0] cmd_data,
   output logic [1:0]       sr_mode,
   output logic             sr_serial_in,
   output logic [WIDTH-1:0] sr_data_in,
   input  logic [WIDTH-1:0] sr_data_out,
   output logic             ser_out,
   output logic             ser_out_valid,
   input  logic             ser_out_ready,
   input  logic             ser_in,
   input  logic             ser_in_valid,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             done
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   localparam logic [1:0] MODE_HOLD  = 2'b00;
   localparam logic [1:0] MODE_LEFT  = 2'b01;
   localparam logic [1:0] MODE_RIGHT = 2'b10;
   localparam logic [1:0] MODE_LOAD  = 2'b11;

   localparam logic [CNT_W-1:0] LEN_FULL = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       op_q, op_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             done_q, done_d;

   logic             is_tx;
   logic             last_bit;
   logic [CNT_W-1:0] len_clamped;
   logic [CNT_W-1:0] rsp_shamt;

   // op[1]=0 selects TX; op[0] then picks the bit order for either direction
   assign is_tx    = ~op_q[1];
   assign last_bit = (cnt_q == CNT_ONE);

   // 0 or anything beyond WIDTH means a full word
   assign len_clamped = ((cmd_len == '0) || (cmd_len > LEN_FULL)) ? LEN_FULL : cmd_len;

   // LSB-first RX fills from the top, so the word is right-aligned by this amount
   assign rsp_shamt = LEN_FULL - len_q;

   // State and latched command register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         len_q   <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         len_q   <= len_d;
         data_q  <= data_d;
         done_q  <= done_d;
      end
   end

   // Next-state and combinational outputs; everything is forced low under reset
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      op_d          = op_q;
      len_d         = len_q;
      data_d        = data_q;
      done_d        = 1'b0;
      cmd_ready     = 1'b0;
      sr_mode       = MODE_HOLD;
      sr_serial_in  = 1'b0;
      sr_data_in    = '0;
      ser_out       = 1'b0;
      ser_out_valid = 1'b0;
      rsp_valid     = 1'b0;
      rsp_data      = '0;

      if (!rst) begin
         case (state_q)
            ST_IDLE: begin
               cmd_ready = 1'b1;
               if (cmd_valid) begin
                  op_d    = cmd_op;
                  len_d   = len_clamped;
                  data_d  = cmd_data;
                  state_d = ST_LOAD;
               end
            end

            ST_LOAD: begin
               // RX starts from a cleared register so short words come out zero-padded
               sr_mode    = MODE_LOAD;
               sr_data_in = is_tx ? data_q : '0;
               cnt_d      = len_q;
               state_d    = ST_SHIFT;
            end

            ST_SHIFT: begin
               if (is_tx) begin
                  ser_out_valid = 1'b1;
                  ser_out       = op_q[0] ? sr_data_out[WIDTH-1] : sr_data_out[0];
                  // Without ready the register holds, keeping ser_out stable
                  if (ser_out_ready) begin
                     sr_mode = op_q[0] ? MODE_LEFT : MODE_RIGHT;
                     cnt_d   = cnt_q - CNT_ONE;
                     if (last_bit) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                     end
                  end
               end else begin
                  if (ser_in_valid) begin
                     sr_mode      = op_q[0] ? MODE_RIGHT : MODE_LEFT;
                     sr_serial_in = ser_in;
                     cnt_d        = cnt_q - CNT_ONE;
                     if (last_bit) begin
                        state_d = ST_RESP;
                     end
                  end
               end
            end

            ST_RESP: begin
               rsp_valid = 1'b1;
               rsp_data  = op_q[0] ? (sr_data_out >> rsp_shamt) : sr_data_out;
               if (rsp_ready) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end

            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   assign done = done_q & ~rst;

endmodule

// File: tb/tb_usr_serial_sequencer.sv
// Testbench for usr_serial_sequencer: a behavioural universal shift register
// closes the loop; expected TX bits and RX words go into scoreboard queues
// when a command is issued and are popped when the link/response handshakes.
module tb_usr_serial_sequencer;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [CNT_W-1:0] cmd_len;
   logic [WIDTH-1:0] cmd_data;
   logic [1:0]       sr_mode;
   logic             sr_serial_in;
   logic [WIDTH-1:0] sr_data_in;
   logic [WIDTH-1:0] sr_data_out;
   logic             ser_out;
   logic             ser_out_valid;
   logic             ser_out_ready;
   logic             ser_in;
   logic             ser_in_valid;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_data;
   logic             done;

   logic [WIDTH-1:0] sr_q = '0;

   int n_cmp = 0;
   int n_err = 0;

   logic             tx_q[$];
   logic [WIDTH-1:0] rsp_q[$];

   usr_serial_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_len(cmd_len), .cmd_data(cmd_data),
      .sr_mode(sr_mode), .sr_serial_in(sr_serial_in), .sr_data_in(sr_data_in),
      .sr_data_out(sr_data_out),
      .ser_out(ser_out), .ser_out_valid(ser_out_valid), .ser_out_ready(ser_out_ready),
      .ser_in(ser_in), .ser_in_valid(ser_in_valid),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .done(done)
   );

   always #5 clk = ~clk;

   // Universal shift register being sequenced
   always_ff @(posedge clk) begin
      case (sr_mode)
         2'b01:   sr_q <= {sr_q[WIDTH-2:0], sr_serial_in};
         2'b10:   sr_q <= {sr_serial_in, sr_q[WIDTH-1:1]};
         2'b11:   sr_q <= sr_data_in;
         default: sr_q <= sr_q;
      endcase
   end
   assign sr_data_out = sr_q;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int eff_len(input logic [CNT_W-1:0] len);
      return ((len == '0) || (int'(len) > WIDTH)) ? WIDTH : int'(len);
   endfunction

   task automatic run_tx(input logic [1:0] op, input logic [WIDTH-1:0] data,
                         input logic [CNT_W-1:0] len, input bit stall, input int abort_after);
      int eff;
      int hs;
      int cyc;
      logic [1:0] exp_mode;
      eff = eff_len(len);
      for (int i = 0; i < eff; i++) tx_q.push_back(op[0] ? data[WIDTH-1-i] : data[i]);
      exp_mode = op[0] ? 2'b01 : 2'b10;

      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_len = len;
      #1;
      chk("tx_accept_ready", 32'(cmd_ready), 32'd1);
      chk("tx_idle_mode", 32'(sr_mode), 32'd0);

      @(negedge clk);
      cmd_valid = 1'b0; cmd_data = '0;
      #1;
      chk("tx_load_mode", 32'(sr_mode), 32'd3);
      chk("tx_load_data", 32'(sr_data_in), 32'(data));
      chk("tx_load_no_valid", 32'(ser_out_valid), 32'd0);

      hs = 0;
      cyc = 0;
      while (hs < eff && cyc < 4 * eff + 8) begin
         if (abort_after > 0 && hs == abort_after) break;
         @(negedge clk);
         ser_out_ready = stall ? (cyc % 2 == 0) : 1'b1;
         #1;
         chk("tx_valid", 32'(ser_out_valid), 32'd1);
         chk("tx_no_done", 32'(done), 32'd0);
         if (tx_q.size() == 0) begin
            chk("tx_queue_underrun", 32'(tx_q.size()), 32'd1);
         end else begin
            chk("tx_bit", 32'(ser_out), 32'(tx_q[0]));
         end
         if (ser_out_ready) begin
            chk("tx_shift_mode", 32'(sr_mode), 32'(exp_mode));
            if (tx_q.size() != 0) void'(tx_q.pop_front());
            hs++;
         end else begin
            chk("tx_stall_mode", 32'(sr_mode), 32'd0);
         end
         cyc++;
      end

      if (abort_after > 0) begin
         // Reset in the middle of the word
         @(negedge clk);
         rst = 1'b1; ser_out_ready = 1'b1;
         #1;
         chk("abort_valid", 32'(ser_out_valid), 32'd0);
         chk("abort_mode", 32'(sr_mode), 32'd0);
         chk("abort_done", 32'(done), 32'd0);
         @(negedge clk);
         rst = 1'b0; ser_out_ready = 1'b0;
         #1;
         chk("abort_post_done", 32'(done), 32'd0);
         chk("abort_post_valid", 32'(ser_out_valid), 32'd0);
         chk("abort_post_ready", 32'(cmd_ready), 32'd1);
         chk("abort_post_rsp", 32'(rsp_valid), 32'd0);
         tx_q.delete();
         return;
      end

      chk("tx_handshakes", 32'(hs), 32'(eff));
      @(negedge clk);
      ser_out_ready = 1'b0;
      #1;
      chk("tx_done", 32'(done), 32'd1);
      chk("tx_end_valid", 32'(ser_out_valid), 32'd0);
      chk("tx_end_mode", 32'(sr_mode), 32'd0);
      chk("tx_end_ready", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      #1;
      chk("tx_done_single", 32'(done), 32'd0);
   endtask

   // bits[i] is the i-th bit placed on the link
   task automatic run_rx(input logic [1:0] op, input logic [CNT_W-1:0] len,
                         input logic [WIDTH-1:0] bits, input int hold, input bit offer);
      int eff;
      int gap;
      logic [WIDTH-1:0] exp;
      logic [1:0] exp_mode;
      eff = eff_len(len);
      exp = '0;
      for (int i = 0; i < eff; i++) begin
         if (op[0]) exp[i] = bits[i];
         else       exp = {exp[WIDTH-2:0], bits[i]};
      end
      rsp_q.push_back(exp);
      exp_mode = op[0] ? 2'b10 : 2'b01;

      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_data = '1;
      #1;
      chk("rx_accept_ready", 32'(cmd_ready), 32'd1);

      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
      chk("rx_load_mode", 32'(sr_mode), 32'd3);
      chk("rx_load_zero", 32'(sr_data_in), 32'd0);

      for (int i = 0; i < eff; i++) begin
         gap = int'($urandom_range(0, 3));
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            ser_in_valid = 1'b0;
            #1;
            chk("rx_gap_mode", 32'(sr_mode), 32'd0);
         end
         @(negedge clk);
         ser_in_valid = 1'b1; ser_in = bits[i];
         #1;
         chk("rx_shift_mode", 32'(sr_mode), 32'(exp_mode));
         chk("rx_serial_in", 32'(sr_serial_in), 32'(bits[i]));
         chk("rx_no_rsp", 32'(rsp_valid), 32'd0);
      end

      @(negedge clk);
      ser_in_valid = 1'b0; ser_in = 1'b0; rsp_ready = 1'b0;
      for (int h = 0; h <= hold; h++) begin
         if (h > 0) @(negedge clk);
         if (offer) begin
            cmd_valid = 1'b1; cmd_op = 2'b01; cmd_len = CNT_W'(1); cmd_data = 8'h80;
         end
         #1;
         chk("rsp_valid", 32'(rsp_valid), 32'd1);
         chk("rsp_hold_data", 32'(rsp_data), 32'(rsp_q[0]));
         chk("rsp_cmd_blocked", 32'(cmd_ready), 32'd0);
         chk("rsp_hold_mode", 32'(sr_mode), 32'd0);
      end

      @(negedge clk);
      rsp_ready = 1'b1;
      #1;
      chk("rsp_valid_hs", 32'(rsp_valid), 32'd1);
      chk("rsp_cmd_blocked_hs", 32'(cmd_ready), 32'd0);
      if (rsp_q.size() == 0) chk("rsp_queue_underrun", 32'(rsp_q.size()), 32'd1);
      else chk("rsp_data", 32'(rsp_data), 32'(rsp_q.pop_front()));

      @(negedge clk);
      rsp_ready = 1'b0;
      #1;
      chk("rx_done", 32'(done), 32'd1);
      chk("rx_end_rsp", 32'(rsp_valid), 32'd0);
      chk("rx_end_ready", 32'(cmd_ready), 32'd1);
      if (!offer) begin
         @(negedge clk);
         #1;
         chk("rx_done_single", 32'(done), 32'd0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout n_cmp=%0d n_err=%0d", n_cmp, n_err);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0; cmd_data = '0;
      ser_out_ready = 1'b0; ser_in = 1'b0; ser_in_valid = 1'b0; rsp_ready = 1'b0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst_mode", 32'(sr_mode), 32'd0);
      chk("rst_valid", 32'(ser_out_valid), 32'd0);
      chk("rst_rsp", 32'(rsp_valid), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("idle_ready", 32'(cmd_ready), 32'd1);
      chk("idle_done", 32'(done), 32'd0);

      // TX LSB-first full word, ready always high
      run_tx(2'b00, 8'hB4, CNT_W'(8), 1'b0, 0);
      // TX MSB-first, 4 bits, alternating ready
      run_tx(2'b01, 8'hB4, CNT_W'(4), 1'b1, 0);
      // Length beyond WIDTH clamps to a full word
      run_tx(2'b01, 8'h3C, CNT_W'(15), 1'b0, 0);

      // Stray RX strobe in IDLE
      @(negedge clk);
      ser_in_valid = 1'b1; ser_in = 1'b1;
      #1;
      chk("stray_mode", 32'(sr_mode), 32'd0);
      chk("stray_serial_in", 32'(sr_serial_in), 32'd0);
      chk("stray_ready", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      ser_in_valid = 1'b0; ser_in = 1'b0;

      // RX MSB-first, len 0 -> 8, bits 1,0,1,0,0,1,1,1; response stalled 5 cycles
      // with a TX command offered that must wait for IDLE
      run_rx(2'b10, CNT_W'(0), 8'b1110_0101, 5, 1'b1);
      @(negedge clk);
      cmd_valid = 1'b0; cmd_data = '0;
      #1;
      chk("late_cmd_load_mode", 32'(sr_mode), 32'd3);
      chk("late_cmd_load_data", 32'(sr_data_in), 32'h80);
      chk("late_cmd_done_single", 32'(done), 32'd0);
      @(negedge clk);
      ser_out_ready = 1'b1;
      #1;
      chk("late_cmd_valid", 32'(ser_out_valid), 32'd1);
      chk("late_cmd_bit", 32'(ser_out), 32'd1);
      chk("late_cmd_mode", 32'(sr_mode), 32'd1);
      @(negedge clk);
      ser_out_ready = 1'b0;
      #1;
      chk("late_cmd_done", 32'(done), 32'd1);

      // RX LSB-first 4 bits 1,1,0,1 -> 0x0B
      run_rx(2'b11, CNT_W'(4), 8'b0000_1011, 0, 1'b0);

      // Reset after 3 TX bits, then a short command
      run_tx(2'b00, 8'h5A, CNT_W'(8), 1'b0, 3);
      run_tx(2'b00, 8'h01, CNT_W'(1), 1'b0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
